// File: rtl/vga_console_pkg.sv
// rtl/vga_console_pkg.sv - shared defaults, state encoding and control codes for the console sequencer
package vga_console_pkg;

  localparam int DEFAULT_NUM_ROWS = 3;
  localparam int DEFAULT_NUM_COLS = 10;
  localparam int NUM_CHARS        = DEFAULT_NUM_ROWS * DEFAULT_NUM_COLS;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCROLL_COPY,
    SCROLL_FILL
  } state_t;

  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] BS        = 8'h08;
  localparam logic [7:0] FF        = 8'h0C;
  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

endpackage

// File: rtl/vga_console_sequencer.sv
// rtl/vga_console_sequencer.sv - terminal byte stream to text-buffer writes with clear and scroll sequencing
// Optional: VGA_CONSOLE_VBLANK_SYNC_EN restricts all buffer activity to vertical blanking.
module vga_console_sequencer
  import vga_console_pkg::*;
#(
  parameter int NUM_ROWS = DEFAULT_NUM_ROWS,
  parameter int NUM_COLS = DEFAULT_NUM_COLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       vblank,
  output logic [4:0] buf_raddr,
  input  logic [6:0] buf_rdata,
  output logic       buf_we,
  output logic [4:0] buf_waddr,
  output logic [6:0] buf_wdata,
  output logic [1:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       busy
);

  localparam int TOTAL_CHARS   = NUM_ROWS * NUM_COLS;
  localparam int LAST_ROW_BASE = (NUM_ROWS - 1) * NUM_COLS;

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [1:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [4:0] cur_addr;
  logic       hold;
  logic       advance;

  assign cur_addr   = 5'(int'(row_q) * NUM_COLS + int'(col_q));
  assign cursor_row = rst ? 2'd0 : row_q;
  assign cursor_col = rst ? 4'd0 : col_q;

`ifndef VGA_CONSOLE_VBLANK_SYNC_EN
  logic unused_vblank;
  assign unused_vblank = vblank;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    in_ready  = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = '0;
    buf_wdata = '0;
    buf_raddr = '0;
    advance   = 1'b0;
    hold      = 1'b0;
`ifdef VGA_CONSOLE_VBLANK_SYNC_EN
    hold      = !vblank;
`endif
    busy      = rst || (state_q != IDLE);

    // A held cycle freezes state and idx so an interrupted sequence resumes in place.
    if (!rst && !hold) begin
      unique case (state_q)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (in_data >= SPACE && in_data <= PRINT_MAX) begin
              buf_we    = 1'b1;
              buf_waddr = cur_addr;
              buf_wdata = in_data[6:0];
              if (col_q == 4'(NUM_COLS - 1)) begin
                col_d   = '0;
                advance = 1'b1;
              end else begin
                col_d = col_q + 4'd1;
              end
            end else if (in_data == LF) begin
              col_d   = '0;
              advance = 1'b1;
            end else if (in_data == CR) begin
              col_d = '0;
            end else if (in_data == BS && col_q != 4'd0) begin
              col_d     = col_q - 4'd1;
              buf_we    = 1'b1;
              buf_waddr = cur_addr - 5'd1;
              buf_wdata = SPACE[6:0];
            end else if (in_data == FF) begin
              row_d   = '0;
              col_d   = '0;
              idx_d   = '0;
              state_d = CLEAR;
            end
          end
        end
        CLEAR: begin
          buf_we    = 1'b1;
          buf_waddr = idx_q;
          buf_wdata = SPACE[6:0];
          if (idx_q == 5'(TOTAL_CHARS - 1)) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        SCROLL_COPY: begin
          // Reads run one row ahead of writes, so each source is read before it is overwritten.
          buf_raddr = idx_q + 5'(NUM_COLS);
          buf_we    = 1'b1;
          buf_waddr = idx_q;
          buf_wdata = buf_rdata;
          idx_d     = idx_q + 5'd1;
          if (idx_q == 5'(LAST_ROW_BASE - 1)) state_d = SCROLL_FILL;
        end
        SCROLL_FILL: begin
          buf_we    = 1'b1;
          buf_waddr = idx_q;
          buf_wdata = SPACE[6:0];
          if (idx_q == 5'(TOTAL_CHARS - 1)) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (advance) begin
        if (row_q == 2'(NUM_ROWS - 1)) begin
          idx_d   = '0;
          state_d = SCROLL_COPY;
        end else begin
          row_d = row_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_console_sequencer.sv
// tb/tb_vga_console_sequencer.sv - randomized byte-stream bench against a screen-level reference model
module tb_vga_console_sequencer;

  localparam int NR = 3;
  localparam int NC = 10;
  localparam int NCH = NR * NC;
  localparam logic [6:0] SP = 7'h20;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       vblank;
  logic [4:0] buf_raddr;
  logic [6:0] buf_rdata;
  logic       buf_we;
  logic [4:0] buf_waddr;
  logic [6:0] buf_wdata;
  logic [1:0] cursor_row;
  logic [3:0] cursor_col;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [6:0] mem [32];
  logic [6:0] screen [NCH];
  logic [6:0] snap [NCH];
  int mrow, mcol;

  always #5 clk = ~clk;

  vga_console_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .vblank(vblank), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata), .buf_we(buf_we),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .busy(busy)
  );

  always @(posedge clk) if (buf_we) mem[buf_waddr] <= buf_wdata;
  assign buf_rdata = mem[buf_raddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Screen-level model: kind 0 = no sequence, 1 = scroll, 2 = clear.
  task automatic model_apply(input logic [7:0] b, output logic ew, output logic [4:0] ea,
                             output logic [6:0] ed, output int kind);
    bit adv = 0;
    ew = 0; ea = 0; ed = 0; kind = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      ew = 1; ea = 5'(mrow * NC + mcol); ed = b[6:0];
      screen[mrow * NC + mcol] = b[6:0];
      if (mcol == NC - 1) begin mcol = 0; adv = 1; end else mcol++;
    end else if (b == 8'h0A) begin
      mcol = 0; adv = 1;
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--; ew = 1; ea = 5'(mrow * NC + mcol); ed = SP;
        screen[mrow * NC + mcol] = SP;
      end
    end else if (b == 8'h0C) begin
      mrow = 0; mcol = 0; kind = 2;
      for (int i = 0; i < NCH; i++) screen[i] = SP;
    end
    if (adv) begin
      if (mrow < NR - 1) mrow++;
      else begin
        kind = 1;
        snap = screen;
        for (int i = 0; i < NCH - NC; i++) screen[i] = screen[i + NC];
        for (int i = NCH - NC; i < NCH; i++) screen[i] = SP;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, output logic we, output logic [4:0] wa,
                      output logic [6:0] wd);
    int n = 0;
    in_valid = 1; in_data = b; #1;
    while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
    check("ready_timeout", 32'(n < 200), 1);
    we = buf_we; wa = buf_waddr; wd = buf_wdata;
    @(negedge clk);
    in_valid = 0; in_data = 0;
  endtask

  task automatic wait_idle(input int kind);
    int k = 0;
    int n = 0;
    logic [6:0] ewd;
    while (n < 200) begin
`ifdef VGA_CONSOLE_VBLANK_SYNC_EN
      vblank = ($urandom_range(0, 2) != 0);
`else
      vblank = 1'b1;
`endif
      #1;
      if (!busy) break;
      check("busy_ready", 32'(in_ready), 0);
      if (vblank) begin
        check("seq_we", 32'(buf_we), 1);
        check("seq_waddr", 32'(buf_waddr), k);
        ewd = SP;
        if (kind == 1 && k < NCH - NC) begin
          check("seq_raddr", 32'(buf_raddr), k + NC);
          ewd = snap[k + NC];
        end
        check("seq_wdata", 32'(buf_wdata), 32'(ewd));
        k++;
      end else begin
        check("hold_we", 32'(buf_we), 0);
      end
      @(negedge clk);
      n++;
    end
    check("seq_len", k, (kind != 0) ? NCH : 0);
    check("idle_we", 32'(buf_we), 0);
    vblank = 1'b1;
  endtask

  task automatic do_byte(input logic [7:0] b);
    logic ew, gw;
    logic [4:0] ea, ga;
    logic [6:0] ed, gd;
    int kind;
    model_apply(b, ew, ea, ed, kind);
    send(b, gw, ga, gd);
    check("acc_we", 32'(gw), 32'(ew));
    if (ew) begin
      check("acc_waddr", 32'(ga), 32'(ea));
      check("acc_wdata", 32'(gd), 32'(ed));
    end
    wait_idle(kind);
    check("cursor_row", 32'(cursor_row), mrow);
    check("cursor_col", 32'(cursor_col), mcol);
  endtask

  task automatic check_mem();
    int bad = 0;
    for (int i = 0; i < NCH; i++) if (mem[i] !== screen[i]) bad++;
    check("mem_image", bad, 0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 15);
    logic [7:0] v;
    if (r < 8) v = 8'($urandom_range(32, 126));
    else if (r == 8) v = 8'h0A;
    else if (r == 9) v = 8'h0D;
    else if (r < 12) v = 8'h08;
    else if (r == 12) v = ($urandom_range(0, 7) == 0) ? 8'h0C : 8'h41;
    else if (r == 13) v = 8'($urandom_range(128, 255));
    else if (r == 14) begin
      v = 8'($urandom_range(0, 31));
      if (v == 8'h08 || v == 8'h0A || v == 8'h0C || v == 8'h0D) v = 8'h1B;
    end else v = 8'h7F;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gw;
    logic [4:0] ga;
    logic [6:0] gd;
    int kind;
    logic ew;
    logic [4:0] ea;
    logic [6:0] ed;
    string txt;

    rst = 1; in_valid = 0; in_data = 0; vblank = 1;
    mrow = 0; mcol = 0;
    for (int i = 0; i < NCH; i++) screen[i] = SP;
    repeat (3) @(negedge clk);
    #1;
    check("rst_we", 32'(buf_we), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_row", 32'(cursor_row), 0);
    check("rst_col", 32'(cursor_col), 0);
    rst = 0;
    wait_idle(2);
    #1;
    check("post_rst_ready", 32'(in_ready), 1);
    check("post_rst_row", 32'(cursor_row), 0);
    check("post_rst_col", 32'(cursor_col), 0);
    check_mem();

    do_byte(8'h41);

    // Fill the last row to force a wrap-driven scroll.
    do_byte(8'h0C);
    do_byte(8'h0A);
    do_byte(8'h0A);
    for (int i = 0; i < NC; i++) do_byte(8'h30 + 8'(i));
    check_mem();

    do_byte(8'h0C);
    txt = "abc";
    for (int i = 0; i < 3; i++) do_byte(txt[i]);
    do_byte(8'h08);
    do_byte(8'h0D);
    do_byte(8'h08);
    check_mem();

    // Reset in the middle of a clear must restart the clear from address 0.
    do_byte(8'h78);
    do_byte(8'h79);
    model_apply(8'h0C, ew, ea, ed, kind);
    send(8'h0C, gw, ga, gd);
    repeat (12) @(negedge clk);
    rst = 1; #1;
    check("abort_we", 32'(buf_we), 0);
    check("abort_ready", 32'(in_ready), 0);
    check("abort_busy", 32'(busy), 1);
    @(negedge clk);
    rst = 0;
    wait_idle(2);
    check("abort_row", 32'(cursor_row), 0);
    check("abort_col", 32'(cursor_col), 0);
    check_mem();

    for (int i = 0; i < 400; i++) begin
      do_byte(rand_byte());
      check_mem();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
